rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Issue-side scoreboard and write-port scheduler for the pipeline's 2-read/1-write register bank. It tracks destination registers with outstanding long-latency results (loads, multi-cycle ops), stalls issue on RAW/WAW hazards against them, and multiplexes the ALU and memory writeback streams onto the bank's single write port (`ptr_wr`, `data_wr`, `wr_en`). A starvation counter forces issue bubbles so that memory writebacks cannot be blocked indefinitely.

## Interface
- `N`, 32: number of architectural registers; register 0 is hard-wired zero.
- `Bits`, 64: data width.
- `MAX_OUT`, 4: maximum outstanding long-latency ops (≥1).
- `MAX_WAIT`, 3: consecutive memory-writeback denials before forced issue stall (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode presents an instruction.
- `issue_rs1`, `issue_rs2`  in  $clog2(N)  source pointers.
- `issue_rd`  in  $clog2(N)  destination pointer.
- `issue_rd_wr`  in  1  instruction writes `issue_rd`.
- `issue_long`  in  1  result returns through memory writeback.
- `issue_stall`  out  1  combinational; instruction not accepted this cycle.
- `wb_alu_valid`  in  1  ALU result valid; always accepted, no backpressure.
- `wb_alu_rd`  in  $clog2(N)  ALU destination.
- `wb_alu_data`  in  Bits  ALU result.
- `wb_mem_valid`  in  1  memory result valid.
- `wb_mem_rd`  in  $clog2(N)  memory destination.
- `wb_mem_data`  in  Bits  memory result.
- `wb_mem_ready`  out  1  combinational; `!wb_alu_valid`.
- `ptr_wr`  out  $clog2(N)  registered write pointer to bank.
- `data_wr`  out  Bits  registered write data to bank.
- `wr_en`  out  1  registered write enable to bank.
- `pending`  out  N  registered per-register pending vector.
- `err_wb`  out  1  sticky: memory writeback to a non-pending register.

## Operation
- Hazard: `hz = pending[rs1] | pending[rs2] | (issue_rd_wr & pending[rd])`, using registered `pending` only (no same-cycle clear bypass).
- `issue_stall = issue_valid & (hz | force_stall | (issue_long & issue_rd_wr & out_cnt == MAX_OUT))`.
- Accept = `issue_valid & !issue_stall`. On accept with `issue_long & issue_rd_wr & rd != 0`: set `pending[rd]`, `out_cnt++`.
- Memory grant = `wb_mem_valid & wb_mem_ready`. On grant: clear `pending[wb_mem_rd]`, `out_cnt--`; if the bit was already 0 (or rd==0), set `err_wb` and leave `out_cnt` unchanged.
- Set and grant in the same cycle: both apply; `out_cnt` is unchanged.
- Write port: ALU has fixed priority. Next `wr_en = (alu_valid & alu_rd != 0) | (grant & mem_rd != 0)`; pointer/data from the selected source. Writes to register 0 never assert `wr_en`.
- Starvation: `wait_cnt` increments (saturating at MAX_WAIT) each cycle `wb_mem_valid & !wb_mem_ready`, and clears on grant or `!wb_mem_valid`. `force_stall = (wait_cnt == MAX_WAIT)`.
- `pending[0]` is constant 0.

## Timing
- Reset (async, `rst`=0): `pending`=0, `out_cnt`=0, `wait_cnt`=0, `wr_en`=0, `ptr_wr`=0, `data_wr`=0, `err_wb`=0. `issue_stall` and `wb_mem_ready` follow their equations immediately; `issue_stall`=0 unless inputs hazard.
- Writeback latency is one cycle: a source accepted in cycle t drives `wr_en`/`ptr_wr`/`data_wr` in cycle t+1.
- Pending clear latency is one cycle: after a grant in cycle t, an issue that depended on that register is accepted at t+1 at the earliest, once `data_wr` has reached the bank.
- Forced stall persists while `wait_cnt == MAX_WAIT`, so the first ALU bubble grants memory and releases the stall on the next cycle.
- Reset mid-operation discards all pending state. Upstream is responsible for flushing in-flight memory ops; a post-reset memory writeback raises `err_wb`.

## Test plan
- Reset: assert `rst`=0 mid-traffic -> all registered outputs are 0 the same cycle; `pending`=0 after release.
- RAW: issue long rd=5; next cycle issue rs1=5 -> `issue_stall`=1. Memory writeback rd=5, data 0xAB granted at t -> `wr_en`=1, `ptr_wr`=5, `data_wr`=0xAB at t+1; stall drops at t+1.
- Conflict: ALU rd=3/0x11 and memory rd=7/0x22 valid in the same cycle -> `wb_mem_ready`=0; port writes 3/0x11, then 7/0x22 the cycle after ALU goes idle.
- Starvation (MAX_WAIT=3): ALU valid every cycle with memory waiting -> `issue_stall`=1 after 3 denials; memory granted on the first ALU bubble; `wait_cnt` returns to 0.
- Capacity: 4 long issues to rd 1..4 -> 5th long issue stalls. Grant for rd=1 -> `out_cnt`=3, and the 5th issue is accepted the next cycle.
- Edge: ALU writeback to rd=0 -> `wr_en` stays 0. Memory writeback to non-pending rd=9 -> `err_wb`=1 and stays set until reset.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - issue scoreboard and single write-port scheduler for a 2R/1W register bank
// Tracks long-latency destinations, stalls RAW/WAW issue, and arbitrates ALU/memory writebacks.
module rf_scoreboard #(
  parameter int N        = 32,
  parameter int Bits     = 64,
  parameter int MAX_OUT  = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [$clog2(N)-1:0] issue_rs1,
  input  logic [$clog2(N)-1:0] issue_rs2,
  input  logic [$clog2(N)-1:0] issue_rd,
  input  logic                 issue_rd_wr,
  input  logic                 issue_long,
  output logic                 issue_stall,
  input  logic                 wb_alu_valid,
  input  logic [$clog2(N)-1:0] wb_alu_rd,
  input  logic [Bits-1:0]      wb_alu_data,
  input  logic                 wb_mem_valid,
  input  logic [$clog2(N)-1:0] wb_mem_rd,
  input  logic [Bits-1:0]      wb_mem_data,
  output logic                 wb_mem_ready,
  output logic [$clog2(N)-1:0] ptr_wr,
  output logic [Bits-1:0]      data_wr,
  output logic                 wr_en,
  output logic [N-1:0]         pending,
  output logic                 err_wb
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [N-1:0]    pending_q, pending_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [PW-1:0]   ptr_wr_q, ptr_wr_d;
  logic [Bits-1:0] data_wr_q, data_wr_d;
  logic            err_wb_q, err_wb_d;

  logic hz, force_stall, at_cap, accept, set_en, grant, clr_ok, alu_wr, mem_wr;

  always_comb begin
    hz          = pending_q[issue_rs1] | pending_q[issue_rs2] | (issue_rd_wr & pending_q[issue_rd]);
    force_stall = (wait_cnt_q == WW'(MAX_WAIT));
    at_cap      = issue_long & issue_rd_wr & (out_cnt_q == CW'(MAX_OUT));
    issue_stall = issue_valid & (hz | force_stall | at_cap);
    accept      = issue_valid & ~issue_stall;
    set_en      = accept & issue_long & issue_rd_wr & (issue_rd != '0);
    wb_mem_ready = ~wb_alu_valid;
    grant       = wb_mem_valid & wb_mem_ready;
    // A grant only retires an outstanding op if the register was really pending.
    clr_ok      = grant & (wb_mem_rd != '0) & pending_q[wb_mem_rd];
    alu_wr      = wb_alu_valid & (wb_alu_rd != '0);
    mem_wr      = grant & (wb_mem_rd != '0);

    pending_d = pending_q;
    if (clr_ok) pending_d[wb_mem_rd] = 1'b0;
    if (set_en) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
    out_cnt_d = out_cnt_q + CW'(set_en) - CW'(clr_ok);
    err_wb_d  = err_wb_q | (grant & ~clr_ok);

    wait_cnt_d = wait_cnt_q;
    if (grant || !wb_mem_valid) wait_cnt_d = '0;
    else if (!force_stall)      wait_cnt_d = wait_cnt_q + WW'(1);

    wr_en_d   = alu_wr | mem_wr;
    ptr_wr_d  = ptr_wr_q;
    data_wr_d = data_wr_q;
    if (alu_wr) begin
      ptr_wr_d  = wb_alu_rd;
      data_wr_d = wb_alu_data;
    end else if (mem_wr) begin
      ptr_wr_d  = wb_mem_rd;
      data_wr_d = wb_mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      out_cnt_q  <= '0;
      wait_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      ptr_wr_q   <= '0;
      data_wr_q  <= '0;
      err_wb_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      out_cnt_q  <= out_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      wr_en_q    <= wr_en_d;
      ptr_wr_q   <= ptr_wr_d;
      data_wr_q  <= data_wr_d;
      err_wb_q   <= err_wb_d;
    end
  end

  assign pending = pending_q;
  assign wr_en   = wr_en_q;
  assign ptr_wr  = ptr_wr_q;
  assign data_wr = data_wr_q;
  assign err_wb  = err_wb_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - directed bench for rf_scoreboard with a per-cycle reference model
module tb_rf_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic        issue_rd_wr = 1'b0, issue_long = 1'b0;
  logic        issue_stall;
  logic        wb_alu_valid = 1'b0;
  logic [4:0]  wb_alu_rd = '0;
  logic [63:0] wb_alu_data = '0;
  logic        wb_mem_valid = 1'b0;
  logic [4:0]  wb_mem_rd = '0;
  logic [63:0] wb_mem_data = '0;
  logic        wb_mem_ready;
  logic [4:0]  ptr_wr;
  logic [63:0] data_wr;
  logic        wr_en;
  logic [31:0] pending;
  logic        err_wb;

  int checks = 0;
  int errors = 0;

  rf_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_wr(issue_rd_wr), .issue_long(issue_long),
    .issue_stall(issue_stall),
    .wb_alu_valid(wb_alu_valid), .wb_alu_rd(wb_alu_rd), .wb_alu_data(wb_alu_data),
    .wb_mem_valid(wb_mem_valid), .wb_mem_rd(wb_mem_rd), .wb_mem_data(wb_mem_data),
    .wb_mem_ready(wb_mem_ready),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en), .pending(pending), .err_wb(err_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: set of outstanding registers, count of them, memory wait streak,
  // and the write the bank should be seeing this cycle.
  bit          m_pend[32];
  int          m_out, m_wait;
  bit          m_err, m_wr;
  logic [4:0]  m_ptr;
  logic [63:0] m_data;

  function automatic bit exp_stall();
    bit hz;
    hz = m_pend[issue_rs1] || m_pend[issue_rs2] || (issue_rd_wr && m_pend[issue_rd]);
    return issue_valid && (hz || m_wait == 3 || (issue_long && issue_rd_wr && m_out == 4));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_out = 0; m_wait = 0; m_err = 0; m_wr = 0; m_ptr = '0; m_data = '0;
    end else begin
      bit grant, acc;
      grant = wb_mem_valid && !wb_alu_valid;
      acc   = issue_valid && !exp_stall();
      if (grant) begin
        if (wb_mem_rd != 0 && m_pend[wb_mem_rd]) begin
          m_pend[wb_mem_rd] = 1'b0;
          m_out--;
        end else m_err = 1'b1;
      end
      if (acc && issue_long && issue_rd_wr && issue_rd != 0) begin
        m_pend[issue_rd] = 1'b1;
        m_out++;
      end
      if (wb_mem_valid && wb_alu_valid) m_wait = (m_wait < 3) ? m_wait + 1 : 3;
      else m_wait = 0;
      if (wb_alu_valid && wb_alu_rd != 0) begin
        m_wr = 1; m_ptr = wb_alu_rd; m_data = wb_alu_data;
      end else if (grant && wb_mem_rd != 0) begin
        m_wr = 1; m_ptr = wb_mem_rd; m_data = wb_mem_data;
      end else m_wr = 0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] pv;
    foreach (m_pend[i]) pv[i] = m_pend[i];
    check("cyc_issue_stall", issue_stall, exp_stall());
    check("cyc_mem_ready", wb_mem_ready, !wb_alu_valid);
    check("cyc_wr_en", wr_en, m_wr);
    if (m_wr) begin
      check("cyc_ptr_wr", ptr_wr, m_ptr);
      check("cyc_data_wr", data_wr, m_data);
    end
    check("cyc_pending", pending, pv);
    check("cyc_err_wb", err_wb, m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_rd_wr = 0; issue_long = 0;
    wb_alu_valid = 0; wb_alu_rd = 0; wb_alu_data = 0;
    wb_mem_valid = 0; wb_mem_rd = 0; wb_mem_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rd_wr, input logic lng);
    issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    issue_rd_wr = rd_wr; issue_long = lng;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [63:0] d);
    wb_mem_valid = 1; wb_mem_rd = rd; wb_mem_data = d;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] d);
    wb_alu_valid = 1; wb_alu_rd = rd; wb_alu_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset
    @(negedge clk);
    check("rst_pending", pending, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_err", err_wb, 0);
    tick(); rst = 1; tick();

    // RAW on a long op
    issue(0, 0, 5, 1, 1); tick();
    check("raw_pending", pending, 32'h20);
    idle(); issue(5, 0, 0, 0, 0); mem(5, 64'hAB);
    @(negedge clk);
    check("raw_stall", issue_stall, 1);
    tick();
    check("raw_wr_en", wr_en, 1);
    check("raw_ptr", ptr_wr, 5);
    check("raw_data", data_wr, 64'hAB);
    wb_mem_valid = 0;
    @(negedge clk);
    check("raw_release", issue_stall, 0);
    tick();

    // WAW against a pending destination
    idle(); issue(0, 0, 6, 1, 1); tick();
    issue(0, 0, 6, 1, 0);
    @(negedge clk);
    check("waw_stall", issue_stall, 1);
    idle(); mem(6, 64'h66); tick(); idle(); tick();

    // ALU/memory conflict
    issue(0, 0, 7, 1, 1); tick();
    idle(); alu(3, 64'h11); mem(7, 64'h22);
    @(negedge clk);
    check("cf_ready", wb_mem_ready, 0);
    tick();
    check("cf_alu_ptr", ptr_wr, 3);
    check("cf_alu_data", data_wr, 64'h11);
    wb_alu_valid = 0; tick();
    check("cf_mem_ptr", ptr_wr, 7);
    check("cf_mem_data", data_wr, 64'h22);
    check("cf_no_err", err_wb, 0);
    idle(); tick();

    // Starvation
    issue(0, 0, 8, 1, 1); tick();
    idle(); mem(8, 64'h88);
    issue(1, 2, 10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      alu(12, 64'h100 + i);
      @(negedge clk);
      check("st_no_stall", issue_stall, 0);
      tick();
    end
    alu(12, 64'h200);
    @(negedge clk);
    check("st_forced", issue_stall, 1);
    tick();
    wb_alu_valid = 0;
    @(negedge clk);
    check("st_bubble_stall", issue_stall, 1);
    check("st_bubble_ready", wb_mem_ready, 1);
    tick();
    check("st_grant_ptr", ptr_wr, 8);
    check("st_grant_data", data_wr, 64'h88);
    wb_mem_valid = 0;
    @(negedge clk);
    check("st_released", issue_stall, 0);
    check("st_model_wait", m_wait, 0);
    idle(); tick();

    // Capacity
    for (int r = 1; r <= 4; r++) begin
      issue(0, 0, r[4:0], 1, 1); tick();
    end
    check("cap_pending", pending, 32'h1E);
    issue(0, 0, 9, 1, 1); mem(1, 64'h1);
    @(negedge clk);
    check("cap_stall", issue_stall, 1);
    tick();
    wb_mem_valid = 0;
    @(negedge clk);
    check("cap_model_out", m_out, 3);
    check("cap_accept", issue_stall, 0);
    tick();
    check("cap_pending2", pending, 32'h21C);
    idle();
    for (int r = 2; r <= 4; r++) begin
      mem(r[4:0], 64'h40 + r); tick();
    end
    mem(9, 64'h99); tick();
    idle(); tick();
    check("cap_drained", pending, 0);

    // Edge: writes to r0 and stray memory writeback
    alu(0, 64'hFF); tick();
    check("edge_r0_wr", wr_en, 0);
    idle(); mem(9, 64'h9); tick();
    check("edge_err", err_wb, 1);
    check("edge_mem_wr", wr_en, 1);
    idle(); mem(0, 64'h5); tick();
    check("edge_r0_mem_wr", wr_en, 0);
    idle(); tick(); tick();
    check("edge_err_sticky", err_wb, 1);

    // Reset mid-traffic
    issue(0, 0, 11, 1, 1); tick();
    idle(); alu(13, 64'h77); issue(11, 0, 0, 0, 0);
    rst = 0; #1;
    check("mr_pending", pending, 0);
    check("mr_wr_en", wr_en, 0);
    check("mr_err", err_wb, 0);
    check("mr_ptr", ptr_wr, 0);
    check("mr_data", data_wr, 0);
    tick();
    idle(); rst = 1; tick();
    check("mr_after", pending, 0);
    mem(11, 64'hB); tick();
    check("mr_stray_err", err_wb, 1);
    idle(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
